output_port_mc: RTL

OUTPUT_PORT_MC -- requirements
Module: output_port_mc

---
 rtl/output_port_pkg.sv | 43 ++++
 rtl/output_port_mc_sync_fifo.sv | 45 ++++
 rtl/output_port_mc.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/output_port_pkg.sv
// Shared definitions for the output-port blocks: default packet field widths,
// channel-index width and packet field offsets.
package output_port_pkg;

    localparam int DEF_PACKET_BITS           = 97;
    localparam int DEF_NUM_LEAF_BITS         = 6;
    localparam int DEF_NUM_PORT_BITS         = 4;
    localparam int DEF_NUM_ADDR_BITS         = 7;
    localparam int DEF_PAYLOAD_BITS          = 64;
    localparam int DEF_NUM_CHANNELS          = 4;
    localparam int DEF_FIFO_DEPTH_BITS       = 6;
    localparam int DEF_FREESPACE_UPDATE_SIZE = 64;
    localparam int DEF_CNT_BITS              = 32;

    function automatic int ch_bits(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    function automatic int min_packet_bits(input int leaf_bits, input int port_bits,
                                           input int addr_bits, input int payload_bits);
        return 1 + leaf_bits + port_bits + addr_bits + payload_bits;
    endfunction

    // Packet layout, MSB first: valid, dst_leaf, dst_port, zero pad, fifo_addr, payload.
    function automatic int valid_bit(input int packet_bits);
        return packet_bits - 1;
    endfunction

    function automatic int leaf_lsb(input int packet_bits, input int leaf_bits);
        return packet_bits - 1 - leaf_bits;
    endfunction

    function automatic int port_lsb(input int packet_bits, input int leaf_bits, input int port_bits);
        return packet_bits - 1 - leaf_bits - port_bits;
    endfunction

    function automatic int addr_lsb(input int payload_bits);
        return payload_bits;
    endfunction

    localparam int CH_BITS = ch_bits(DEF_NUM_CHANNELS);

endpackage

// File: rtl/output_port_mc_sync_fifo.sv
// Single-clock FIFO with a registered read port (data valid the cycle after rd_en).
module sync_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_BITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]    mem [2**DEPTH_BITS];
    logic [DEPTH_BITS:0] wr_ptr;
    logic [DEPTH_BITS:0] rd_ptr;
    logic                do_wr;
    logic                do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                   (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (DEPTH_BITS+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (DEPTH_BITS+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; pointers alone define validity, and this keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
        if (do_rd) rd_data <= mem[rd_ptr[DEPTH_BITS-1:0]];
    end

endmodule

// File: rtl/output_port_mc.sv
// Multi-channel output port: per-channel FIFOs with credit flow control,
// round-robin arbitration onto one network output, and full-cycle statistics.
module output_port_mc
    import output_port_pkg::*;
#(
    parameter int PACKET_BITS           = DEF_PACKET_BITS,
    parameter int NUM_LEAF_BITS         = DEF_NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS         = DEF_NUM_PORT_BITS,
    parameter int NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS,
    parameter int PAYLOAD_BITS          = DEF_PAYLOAD_BITS,
    parameter int NUM_CHANNELS          = DEF_NUM_CHANNELS,
    parameter int FIFO_DEPTH_BITS       = DEF_FIFO_DEPTH_BITS,
    parameter int FREESPACE_UPDATE_SIZE = DEF_FREESPACE_UPDATE_SIZE,
    parameter int CNT_BITS              = DEF_CNT_BITS,
    localparam int CH_BITS              = ch_bits(NUM_CHANNELS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CH_BITS-1:0]               cfg_ch,
    input  logic [NUM_LEAF_BITS-1:0]         cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]         cfg_dst_port,
    input  logic                             update_dst_en,
    input  logic [NUM_ADDR_BITS-1:0]         cfg_fifo_addr,
    input  logic                             update_fifo_addr_en,
    input  logic [NUM_ADDR_BITS-1:0]         cfg_freespace,
    input  logic                             update_freespace_en,
    input  logic                             add_freespace_en,
    input  logic [NUM_CHANNELS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_CHANNELS-1:0]          vld_user2b_out,
    output logic [NUM_CHANNELS-1:0]          ack_b_out2user,
    input  logic                             rd_en_sel,
    output logic [PACKET_BITS-1:0]           internal_out,
    output logic                             empty,
    input  logic                             is_done_mode,
    output logic [NUM_CHANNELS*CNT_BITS-1:0] output_port_full_cnt,
    output logic [NUM_CHANNELS-1:0]          output_port_stall_condition
);

    localparam int          VALID_BIT  = valid_bit(PACKET_BITS);
    localparam int          LEAF_LSB   = leaf_lsb(PACKET_BITS, NUM_LEAF_BITS);
    localparam int          PORT_LSB   = port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
    localparam int          ADDR_LSB   = addr_lsb(PAYLOAD_BITS);
    localparam logic [31:0] CREDIT_MAX = 32'((1 << NUM_ADDR_BITS) - 1);

    if (PACKET_BITS < min_packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS)) begin : g_bad_width
        $error("output_port_mc: PACKET_BITS too small for header plus payload");
    end

    logic [NUM_CHANNELS-1:0]                    fifo_full;
    logic [NUM_CHANNELS-1:0]                    fifo_empty;
    logic [NUM_CHANNELS-1:0]                    eligible;
    logic [NUM_CHANNELS-1:0][PAYLOAD_BITS-1:0]  rd_data_vec;
    logic [NUM_CHANNELS-1:0][NUM_LEAF_BITS-1:0] leaf_vec;
    logic [NUM_CHANNELS-1:0][NUM_PORT_BITS-1:0] port_vec;
    logic [NUM_CHANNELS-1:0][NUM_ADDR_BITS-1:0] addr_vec;

    logic [CH_BITS-1:0]       rr_ptr;
    logic [CH_BITS-1:0]       grant_ch;
    logic                     grant_vld;
    logic                     pop;
    logic                     out_valid;
    logic [CH_BITS-1:0]       out_ch;
    logic [NUM_LEAF_BITS-1:0] out_leaf;
    logic [NUM_PORT_BITS-1:0] out_port;
    logic [NUM_ADDR_BITS-1:0] out_addr;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = rr_ptr;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % NUM_CHANNELS;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_BITS'(idx);
            end
        end
    end

    assign pop   = rd_en_sel && grant_vld;
    assign empty = ~|eligible;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic                     sel;
        logic                     pop_c;
        logic [NUM_LEAF_BITS-1:0] leaf_q;
        logic [NUM_PORT_BITS-1:0] port_q;
        logic [NUM_ADDR_BITS-1:0] addr_q;
        logic [NUM_ADDR_BITS-1:0] credit_q;
        logic [NUM_ADDR_BITS-1:0] credit_next;
        logic [31:0]              credit_sum;
        logic [CNT_BITS-1:0]      cnt_q;

        sync_fifo #(
            .WIDTH      (PAYLOAD_BITS),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (vld_user2b_out[c]),
            .wr_data (din_leaf_user2interface[c*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_en   (pop_c),
            .rd_data (rd_data_vec[c]),
            .full    (fifo_full[c]),
            .empty   (fifo_empty[c])
        );

        assign sel        = (cfg_ch == CH_BITS'(c));
        assign pop_c      = pop && (grant_ch == CH_BITS'(c));
        assign eligible[c] = !fifo_empty[c] && (credit_q != '0);
        assign credit_sum = 32'(credit_q) + 32'(FREESPACE_UPDATE_SIZE) - 32'(pop_c);

        assign ack_b_out2user[c]              = ~fifo_full[c];
        assign output_port_stall_condition[c] = ~is_done_mode && vld_user2b_out[c] && fifo_full[c];
        assign output_port_full_cnt[c*CNT_BITS +: CNT_BITS] = cnt_q;
        assign leaf_vec[c] = leaf_q;
        assign port_vec[c] = port_q;
        assign addr_vec[c] = addr_q;

        // A same-cycle pop is folded into the refill so add+pop nets STEP-1.
        always_comb begin
            credit_next = credit_q;
            if (sel && update_freespace_en)
                credit_next = cfg_freespace;
            else if (sel && add_freespace_en)
                credit_next = (credit_sum > CREDIT_MAX) ? '1 : credit_sum[NUM_ADDR_BITS-1:0];
            else if (pop_c)
                credit_next = credit_q - NUM_ADDR_BITS'(1);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                leaf_q   <= '0;
                port_q   <= '0;
                addr_q   <= '0;
                credit_q <= '1;
                cnt_q    <= '0;
            end else begin
                credit_q <= credit_next;
                if (sel && update_dst_en) begin
                    leaf_q <= cfg_dst_leaf;
                    port_q <= cfg_dst_port;
                end
                if (sel && update_fifo_addr_en)
                    addr_q <= cfg_fifo_addr;
                else if (pop_c)
                    addr_q <= addr_q + NUM_ADDR_BITS'(1);
                if (fifo_full[c] && !is_done_mode && (cnt_q != '1))
                    cnt_q <= cnt_q + CNT_BITS'(1);
            end
        end
    end

    // Header is snapshotted at pop time; the payload arrives from the FIFO read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            rr_ptr    <= CH_BITS'(NUM_CHANNELS - 1);
            out_ch    <= '0;
            out_leaf  <= '0;
            out_port  <= '0;
            out_addr  <= '0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                rr_ptr   <= grant_ch;
                out_ch   <= grant_ch;
                out_leaf <= leaf_vec[grant_ch];
                out_port <= port_vec[grant_ch];
                out_addr <= addr_vec[grant_ch];
            end
        end
    end

    always_comb begin
        internal_out = '0;
        if (out_valid) begin
            internal_out[VALID_BIT]                       = 1'b1;
            internal_out[LEAF_LSB +: NUM_LEAF_BITS]       = out_leaf;
            internal_out[PORT_LSB +: NUM_PORT_BITS]       = out_port;
            internal_out[ADDR_LSB +: NUM_ADDR_BITS]       = out_addr;
            internal_out[0 +: PAYLOAD_BITS]               = rd_data_vec[out_ch];
        end
    end

endmodule
